// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment stopwatch display: conversion FSM
// states, BCD geometry, segment patterns and the per-step dabble adjust.
package seg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      UPDATE = 2'd2
   } conv_state_t;

   localparam int BIN_W = 13;            // binary seconds input width
   localparam int NDIG  = 4;             // thousands..units
   localparam int DIG_W = 4;             // one BCD nibble
   localparam int BCD_W = NDIG * DIG_W;  // 16-bit packed BCD
   localparam int STEPS = BIN_W;         // one dabble step per input bit

   // active-low segments, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic logic [6:0] seg_decode(input logic [DIG_W-1:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;  // non-BCD codes never reach the display
      endcase
      return s;
   endfunction

   // add 3 to every nibble >= 5 so the following left shift carries into the next decade
   function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < NDIG; i++) begin
         if (b[i*DIG_W +: DIG_W] >= 4'd5)
            r[i*DIG_W +: DIG_W] = b[i*DIG_W +: DIG_W] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/seg_display_bin2bcd.sv
// Sequential double-dabble: one shift/adjust step per clock, 13 steps per
// conversion. bcd is valid while done is high (the UPDATE cycle).
module bin2bcd
   import seg_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [BIN_W-1:0] din,
   output logic [BCD_W-1:0] bcd,
   output logic             done,
   output logic             busy
);

   conv_state_t      state;
   logic [BIN_W-1:0] bin_sr;
   logic [BCD_W-1:0] work;
   logic [3:0]       step;
   logic [BCD_W-1:0] adj;

   assign adj  = bcd_adjust(work);
   assign bcd  = work;
   assign done = (state == UPDATE);

   // conversion FSM: capture on start, 13 dabble steps, one UPDATE cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         bin_sr <= '0;
         work   <= '0;
         step   <= '0;
         busy   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  bin_sr <= din;
                  work   <= '0;
                  step   <= '0;
                  busy   <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               // adjust then shift: top adjusted bit drops out, 8191 fits in 4 decades
               work   <= {adj[BCD_W-2:0], bin_sr[BIN_W-1]};
               bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
               step   <= step + 4'd1;
               if (step == 4'(STEPS - 1))
                  state <= UPDATE;
            end
            UPDATE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/seg_display.sv
// Four-digit multiplexed seven-segment display for the stopwatch seconds count.
// Converts value to BCD whenever it changes, scans one digit per refresh slot,
// and optionally blanks leading zeros.
module seg_display
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV = 100000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [BIN_W-1:0] value,
   input  logic             blank_lead,
   output logic [6:0]       seg,
   output logic [NDIG-1:0]  an,
   output logic             busy
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CMAX = CW'(REFRESH_DIV - 1);

   logic [BIN_W-1:0]           last;
   logic [BIN_W-1:0]           pend;
   logic                       force_cnv;
   logic                       start;
   logic [BCD_W-1:0]           bcd;
   logic                       done;
   logic [NDIG-1:0][DIG_W-1:0] disp;
   logic [CW-1:0]              cnt;
   logic [1:0]                 idx;
   logic [NDIG-1:0]            blank;

   // a new conversion is wanted after reset or whenever the input moved
   assign start = force_cnv | (value != last);

   bin2bcd u_bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .din   (value),
      .bcd   (bcd),
      .done  (done),
      .busy  (busy)
   );

   // track the value in flight and commit digits + last value on done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         force_cnv <= 1'b1;
         pend      <= '0;
         last      <= '0;
         disp      <= '0;
      end else begin
         if (!busy && start) begin
            pend      <= value;
            force_cnv <= 1'b0;
         end
         if (done) begin
            disp <= bcd;
            last <= pend;
         end
      end
   end

   // refresh divider; digit index advances on each wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt == CMAX) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // digit i blanks when every digit from i upward is zero; units never blanks
   always_comb begin
      logic above_zero;
      above_zero = 1'b1;
      blank      = '0;
      for (int i = NDIG - 1; i >= 1; i--) begin
         above_zero = above_zero & (disp[i] == 4'd0);
         blank[i]   = blank_lead & above_zero;
      end
   end

   // registered anode/segment drive, both following idx one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= 4'b1110;
         seg <= SEG_0;
      end else begin
         an  <= ~(4'b0001 << idx);
         seg <= blank[idx] ? SEG_BLANK : seg_decode(disp[idx]);
      end
   end

endmodule

// File: tb/tb_seg_display.sv
// Bench for seg_display with a 4-cycle refresh slot: directed and random values,
// checked against decimal digit arithmetic on the applied value.
module tb_seg_display;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [12:0] value = '0;
   logic        blank_lead = 1'b0;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        busy;

   int errors = 0;
   int checks = 0;

   localparam logic [6:0] PAT [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                       7'b0000000, 7'b0010000};

   seg_display #(.REFRESH_DIV(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value      (value),
      .blank_lead (blank_lead),
      .seg        (seg),
      .an         (an),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // expected pattern of decimal position pos (0 = units) of v
   function automatic logic [6:0] model_seg(int v, bit bl, int pos);
      int p10;
      int d;
      p10 = (pos == 0) ? 1 : (pos == 1) ? 10 : (pos == 2) ? 100 : 1000;
      d   = (v / p10) % 10;
      if (bl && pos > 0 && v < p10) return 7'b1111111;
      return PAT[d];
   endfunction

   function automatic int an_pos(logic [3:0] a);
      case (a)
         4'b1110: return 0;
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         default: return -1;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // advance to the next falling edge and check the anode one-hot invariant
   task automatic tick();
      @(negedge clk);
      if (rst_n) chk("an_onehot", $countones(~an), 1);
   endtask

   // expects busy to rise on the next edge, last 14 cycles, then waits for seg to follow
   task automatic conv(input string tag);
      int n;
      n = 0;
      tick();
      chk({tag, "_busy_rise"}, busy, 1'b1);
      while (busy === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      chk({tag, "_busy_len"}, n, 14);
      tick();
   endtask

   // watch n cycles of scanning; every slot's seg, slot length and order are checked
   task automatic scan(input int v, input bit bl, input int n);
      int pos;
      int prev;
      int run;
      bit first;
      logic [3:0] seen;
      prev = -2; run = 0; first = 1'b1; seen = '0;
      for (int i = 0; i < n; i++) begin
         tick();
         pos = an_pos(an);
         if (pos >= 0) begin
            seen[pos] = 1'b1;
            chk($sformatf("seg_v%0d_bl%0d_pos%0d", v, bl, pos), seg, model_seg(v, bl, pos));
         end
         if (prev != -2 && pos != prev) begin
            chk("slot_order", pos, (prev + 1) % 4);
            if (!first) chk("slot_len", run, 4);
            first = 1'b0;
            run = 1;
         end else begin
            run++;
         end
         prev = pos;
      end
      chk($sformatf("all_slots_v%0d", v), seen, 4'hf);
   endtask

   initial begin
      int n;
      int v;
      int pos;
      bit bl;

      // reset state
      repeat (3) tick();
      chk("rst_an", an, 4'b1110);
      chk("rst_seg", seg, 7'b1000000);
      chk("rst_busy", busy, 1'b0);

      // forced conversion of 0 after release
      rst_n = 1'b1;
      conv("c0");
      scan(0, 1'b0, 20);

      value = 13'd1234; blank_lead = 1'b0;
      conv("c1234");
      scan(1234, 1'b0, 20);

      value = 13'd7; blank_lead = 1'b1;
      conv("c7");
      scan(7, 1'b1, 20);

      // interior zero is not a leading zero
      value = 13'd100;
      conv("c100");
      scan(100, 1'b1, 20);

      // 59 -> 60 while 59 is still shifting
      value = 13'd59; blank_lead = 1'b0;
      n = 0;
      tick();
      while (busy === 1'b1 && n < 40) begin
         n++;
         if (n == 5) value = 13'd60;
         tick();
      end
      chk("c59_busy_len", n, 14);
      chk("c59_idle_gap", busy, 1'b0);
      tick();
      chk("c60_restart", busy, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick();
         pos = an_pos(an);
         if (pos >= 0) chk($sformatf("hold59_pos%0d", pos), seg, model_seg(59, 1'b0, pos));
      end
      n = 10;
      while (busy === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      chk("c60_busy_len", n, 14);
      tick();
      scan(60, 1'b0, 20);

      value = 13'd8191;
      conv("c8191");
      scan(8191, 1'b0, 20);

      // all-zero value with blanking keeps the units digit
      value = 13'd0; blank_lead = 1'b1;
      conv("c0b");
      scan(0, 1'b1, 20);

      // random values and blanking
      for (int k = 0; k < 6; k++) begin
         v = int'($urandom_range(8191));
         if (v == int'(value)) v = v ^ 1;
         bl = 1'($urandom_range(1));
         value = 13'(v); blank_lead = bl;
         conv("crand");
         scan(v, bl, 20);
      end

      // reset in the middle of a conversion
      value = value ^ 13'h155;
      repeat (5) tick();
      chk("mid_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("async_an", an, 4'b1110);
      chk("async_seg", seg, 7'b1000000);
      chk("async_busy", busy, 1'b0);
      repeat (2) tick();
      rst_n = 1'b1;
      conv("creset");
      scan(int'(value), blank_lead, 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg_display.md
SEG_DISPLAY -- requirements
Module: seg_display

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot (1 kHz slot rate at 100 MHz); legal range 2..2^20.
REQ-002 Port clk  input  1  system clock, all state on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port value  input  13  binary seconds count from the stopwatch core, 0..8191.
REQ-005 Port blank_lead  input  1  1 = suppress leading-zero digits.
REQ-006 Port seg  output  7  segment drive, active-low, seg[0]=a ... seg[6]=g.
REQ-007 Port an  output  4  digit anode enable, active-low, an[0] = units digit.
REQ-008 Port busy  output  1  high while a binary-to-BCD conversion is in progress.

Function
REQ-009 Conversion FSM SHALL have states IDLE, SHIFT, UPDATE.
REQ-010 IDLE: if value differs from last converted value, or force flag set, capture value, clear shift count, clear force flag, go SHIFT; else stay.
REQ-011 SHIFT: 13 double-dabble steps, one per cycle (add 3 to each BCD nibble >= 5, then shift left 1); after 13th step go UPDATE.
REQ-012 UPDATE: load 4-nibble display register (thousands..units), record converted value, go IDLE.
REQ-013 Latency: value change sampled in IDLE at edge N -> display register holds new digits after edge N+14.
REQ-014 busy SHALL be high exactly in SHIFT and UPDATE.
REQ-015 value changes during SHIFT/UPDATE SHALL be ignored by the running conversion; mismatch re-detected on return to IDLE, triggering a new conversion.
REQ-016 Refresh counter counts 0..REFRESH_DIV-1 and wraps; on wrap, digit index increments 0->1->2->3->0.
REQ-017 an SHALL be one-hot active-low for current index: 0->4'b1110, 1->4'b1101, 2->4'b1011, 3->4'b0111; never two digits enabled.
REQ-018 seg SHALL show decoded nibble of current index; standard 0-9 patterns (e.g. 0 = 7'b1000000, 8 = 7'b0000000, 1 = 7'b1111001).
REQ-019 With blank_lead=1, every digit more significant than highest nonzero digit SHALL drive seg=7'b1111111; units digit never blanked.
REQ-020 seg and an SHALL be registered, changing one cycle after index change; an and seg change on same edge.
REQ-021 Display register update during an active slot SHALL take effect on the next registered seg output (no waiting for slot end).

Reset
REQ-022 rst_n low SHALL immediately force: FSM IDLE, force flag 1, display register 0, last value 0, counter 0, index 0, busy 0, an=4'b1110, seg=7'b1000000.
REQ-023 Reset asserted mid-conversion SHALL abort it; after release the first IDLE cycle starts a fresh conversion of current value.

Structure
REQ-024 Shared package seg_pkg SHALL hold FSM state encodings, the 10 digit segment constants, blank constant 7'b1111111 and BCD width (4 digits x 4 bits).
REQ-025 Sub-module bin2bcd SHALL contain the sequential double-dabble (start, 13-bit in, 16-bit BCD out, done); seg_display holds refresh, mux and decode.
REQ-026 Implementation SHALL be synthesizable, single clock domain, no latches.

Verification (bench uses REFRESH_DIV=4)
REQ-027 Reset release, value=0 -> busy high 14 cycles, then an cycles 1110/1101/1011/0111 every 4 clocks, all seg=7'b1000000.
REQ-028 value=1234, blank_lead=0 -> 15 cycles later digits shown units..thousands = 4,3,2,1 on an[0..3].
REQ-029 value=7, blank_lead=1 -> an[0] slot seg=7'b1111000 ("7"), other three slots seg=7'b1111111.
REQ-030 value 59->60 applied mid-SHIFT of 59 -> 59 displayed first, second conversion starts on IDLE return, 60 displayed ~29 cycles after first change.
REQ-031 value=8191 -> digits 8,1,9,1; rst_n pulsed low during subsequent conversion -> outputs instantly at reset values, reconversion completes 14 cycles after release.
REQ-032 Assertion throughout: an always exactly one zero bit; busy never high in IDLE.
